mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the core's instruction-fetch (IF) and
//  load/store (LS) requesters. Each requester uses a valid/ready request and a one-cycle
//  response pulse. LS has fixed priority, with a starvation guard for IF and a timeout
//  watchdog on the memory side. Sits between riscv_top's fetch/LSU logic and the memory.
// PARAMETERS
//  AW            32  address width (byte address)
//  DW            32  data width
//  STARVE_LIMIT  4   consecutive IF-lost arbitrations before IF is forced to win
//  TIMEOUT       16  max cycles in ACCESS waiting for mem_ack before abort (>=2)
// PORTS
//  clk           in   1     clock, rising edge
//  rst           in   1     synchronous, active-high reset
//  if_req_valid  in   1     fetch request
//  if_req_addr   in   AW    fetch address
//  if_req_ready  out  1     fetch request accepted this cycle when valid&ready
//  if_rsp_valid  out  1     one-cycle fetch response pulse
//  if_rsp_data   out  DW    instruction word; valid with if_rsp_valid
//  if_rsp_err    out  1     fetch timed out; valid with if_rsp_valid
//  ls_req_valid  in   1     load/store request
//  ls_req_we     in   1     1 = store, 0 = load
//  ls_req_addr   in   AW    load/store address
//  ls_req_wdata  in   DW    store data
//  ls_req_wstrb  in   DW/8  store byte enables
//  ls_req_ready  out  1     load/store request accepted when valid&ready
//  ls_rsp_valid  out  1     one-cycle LS response pulse (loads and stores)
//  ls_rsp_rdata  out  DW    load data; 0 for stores
//  ls_rsp_err    out  1     LS timed out; valid with ls_rsp_valid
//  mem_req       out  1     access in progress; held high until mem_ack or abort
//  mem_we        out  1     write enable
//  mem_addr      out  AW    registered address
//  mem_wdata     out  DW    registered write data
//  mem_wstrb     out  DW/8  registered byte enables; 0 for reads
//  mem_ack       in   1     memory completes the access this cycle
//  mem_rdata     in   DW    read data; valid when mem_ack=1
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, starve_cnt=0, timer=0. Reset mid-access abandons the
//   access: no response is issued and mem_req=0 in the cycle after reset is sampled.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE: ready is combinational, high only for the winner, and only in IDLE.
//   Winner = LS if ls_req_valid && !(if_req_valid && starve_cnt>=STARVE_LIMIT), else IF if
//   if_req_valid. At most one ready is high per cycle.
//   On handshake: register the owner and request fields, timer=0, go to ACCESS.
//  starve_cnt: increments on each IDLE handshake where IF is valid and LS wins; clears on
//   an IF grant; saturates at STARVE_LIMIT.
//  ACCESS: mem_req=1, and mem_* fields are stable for the whole state. timer increments
//   every cycle. mem_ack samples mem_rdata into the response register, sets err=0, and
//   goes to RESP. If timer reaches TIMEOUT-1 without mem_ack, sets err=1 and rdata=0,
//   drops mem_req, and goes to RESP. mem_ack outside ACCESS is ignored.
//  RESP: exactly one cycle. The owner's rsp_valid=1 with data and err; the other
//   requester's rsp outputs are 0. Then go to IDLE. Both readys are 0 here.
//  Latency: handshake at edge T gives mem_req high from cycle T+1. mem_ack in cycle T+k
//   gives rsp_valid in cycle T+k+1 and the next possible handshake in cycle T+k+2.
//  rsp_data and rsp_rdata hold their last value while rsp_valid=0. Requester inputs are
//   don't-care outside the handshake cycle.
// TESTING
//  1 IF-only read 0x100, mem_ack after 2 cycles with 0x00500093 -> if_rsp_valid 1 cycle,
//    data 0x00500093, err 0; mem_req high for exactly 2 cycles.
//  2 IF and LS valid in the same IDLE cycle (LS store 0x200, data 0xDEADBEEF, wstrb 0xF)
//    -> ls_req_ready=1, if_req_ready=0; mem_we=1, mem_wstrb=0xF; ls_rsp_rdata=0; IF is
//    served next.
//  3 LS valid continuously, IF valid -> LS wins 4 times, the 5th grant goes to IF,
//    starve_cnt returns to 0.
//  4 LS load with mem_ack never asserted -> mem_req drops after 16 cycles; ls_rsp_valid=1,
//    err=1, rdata=0.
//  5 rst asserted in the 2nd ACCESS cycle -> next cycle mem_req=0, no rsp pulse; a fresh
//    IF request is then accepted normally.
//  6 Spurious mem_ack in IDLE/RESP -> no state change, no extra response.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/LS arbiter for a single-port unified memory
// LS has fixed priority; IF is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_valid,
  input  logic [AW-1:0]   if_req_addr,
  output logic            if_req_ready,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  output logic            if_rsp_err,
  input  logic            ls_req_valid,
  input  logic            ls_req_we,
  input  logic [AW-1:0]   ls_req_addr,
  input  logic [DW-1:0]   ls_req_wdata,
  input  logic [DW/8-1:0] ls_req_wstrb,
  output logic            ls_req_ready,
  output logic            ls_rsp_valid,
  output logic [DW-1:0]   ls_rsp_rdata,
  output logic            ls_rsp_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic [DW-1:0]     if_rsp_data_q, if_rsp_data_d;
  logic              if_rsp_err_q, if_rsp_err_d;
  logic              ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DW-1:0]     ls_rsp_rdata_q, ls_rsp_rdata_d;
  logic              ls_rsp_err_q, ls_rsp_err_d;

  logic              if_starved;
  logic              ls_win;
  logic              if_win;
  logic              done;
  logic              rsp_err;
  logic [DW-1:0]     rsp_data;

  // Grants are only offered in IDLE; reset suppresses them so no handshake is lost.
  always_comb begin
    if_starved = (starve_cnt_q >= SW'(STARVE_LIMIT));
    ls_win     = 1'b0;
    if_win     = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (ls_req_valid && !(if_req_valid && if_starved)) begin
        ls_win = 1'b1;
      end else if (if_req_valid) begin
        if_win = 1'b1;
      end
    end
  end

  assign if_req_ready = if_win;
  assign ls_req_ready = ls_win;

  always_comb begin
    state_d        = state_q;
    owner_ls_d     = owner_ls_q;
    timer_d        = timer_q;
    starve_cnt_d   = starve_cnt_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wstrb_d    = mem_wstrb_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    if_rsp_err_d   = 1'b0;
    ls_rsp_valid_d = 1'b0;
    ls_rsp_rdata_d = ls_rsp_rdata_q;
    ls_rsp_err_d   = 1'b0;
    done           = 1'b0;
    rsp_err        = 1'b0;
    rsp_data       = '0;

    case (state_q)
      IDLE: begin
        if (ls_win || if_win) begin
          state_d    = ACCESS;
          owner_ls_d = ls_win;
          timer_d    = '0;
          mem_req_d  = 1'b1;
          if (ls_win) begin
            mem_we_d    = ls_req_we;
            mem_addr_d  = ls_req_addr;
            mem_wdata_d = ls_req_wdata;
            mem_wstrb_d = ls_req_we ? ls_req_wstrb : '0;
            if (if_req_valid && !if_starved) begin
              starve_cnt_d = starve_cnt_q + SW'(1);
            end
          end else begin
            mem_we_d     = 1'b0;
            mem_addr_d   = if_req_addr;
            mem_wdata_d  = '0;
            mem_wstrb_d  = '0;
            starve_cnt_d = '0;
          end
        end
      end

      ACCESS: begin
        timer_d = timer_q + TW'(1);
        done    = mem_ack || (timer_q == TW'(TIMEOUT - 1));
        if (done) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          rsp_err   = !mem_ack;
          // Stores and aborted accesses return zero data.
          rsp_data  = (mem_ack && !mem_we_q) ? mem_rdata : '0;
          if (owner_ls_q) begin
            ls_rsp_valid_d = 1'b1;
            ls_rsp_err_d   = rsp_err;
            ls_rsp_rdata_d = rsp_data;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_err_d   = rsp_err;
            if_rsp_data_d  = rsp_data;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_ls_q     <= 1'b0;
      timer_q        <= '0;
      starve_cnt_q   <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      if_rsp_err_q   <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_rdata_q <= '0;
      ls_rsp_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_ls_q     <= owner_ls_d;
      timer_q        <= timer_d;
      starve_cnt_q   <= starve_cnt_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrb_q    <= mem_wstrb_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      if_rsp_err_q   <= if_rsp_err_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      ls_rsp_rdata_q <= ls_rsp_rdata_d;
      ls_rsp_err_q   <= ls_rsp_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign if_rsp_err   = if_rsp_err_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign ls_rsp_rdata = ls_rsp_rdata_q;
  assign ls_rsp_err   = ls_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        if_rsp_err;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic [3:0]  ls_req_wstrb;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_rdata;
  logic        ls_rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks;
  int errors;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .if_rsp_err   (if_rsp_err),
    .ls_req_valid (ls_req_valid),
    .ls_req_we    (ls_req_we),
    .ls_req_addr  (ls_req_addr),
    .ls_req_wdata (ls_req_wdata),
    .ls_req_wstrb (ls_req_wstrb),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_rdata (ls_rsp_rdata),
    .ls_rsp_err   (ls_rsp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int  n;
    logic exp_ls;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0;
    ls_req_valid = 1'b0;
    ls_req_we    = 1'b0;
    ls_req_addr  = 32'h0;
    ls_req_wdata = 32'h0;
    ls_req_wstrb = 4'h0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'h0;

    // Reset state
    cyc();
    cyc();
    mid();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wstrb", mem_wstrb, 4'h0);
    chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
    chk("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
    chk("rst_if_req_ready", if_req_ready, 1'b0);
    cyc();
    if_req_valid = 1'b0;
    rst          = 1'b0;
    cyc();

    // 1: IF-only read, ack in 2nd ACCESS cycle
    if_req_valid = 1'b1;
    if_req_addr  = 32'h100;
    mid();
    chk("t1_if_ready", if_req_ready, 1'b1);
    chk("t1_ls_ready", ls_req_ready, 1'b0);
    cyc();
    if_req_valid = 1'b0;
    mid();
    chk("t1_mem_req_c1", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", mem_we, 1'b0);
    chk("t1_mem_wstrb", mem_wstrb, 4'h0);
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 32'h00500093;
    mid();
    chk("t1_mem_req_c2", mem_req, 1'b1);
    chk("t1_no_early_rsp", if_rsp_valid, 1'b0);
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    mid();
    chk("t1_mem_req_resp", mem_req, 1'b0);
    chk("t1_if_rsp_valid", if_rsp_valid, 1'b1);
    chk("t1_if_rsp_data", if_rsp_data, 32'h00500093);
    chk("t1_if_rsp_err", if_rsp_err, 1'b0);
    chk("t1_ls_rsp_valid", ls_rsp_valid, 1'b0);
    cyc();
    mid();
    chk("t1_if_rsp_pulse", if_rsp_valid, 1'b0);
    chk("t1_if_rsp_hold", if_rsp_data, 32'h00500093);

    // 2: simultaneous IF and LS store; LS wins, IF served next
    cyc();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h104;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    ls_req_addr  = 32'h200;
    ls_req_wdata = 32'hDEADBEEF;
    ls_req_wstrb = 4'hF;
    mid();
    chk("t2_ls_ready", ls_req_ready, 1'b1);
    chk("t2_if_ready", if_req_ready, 1'b0);
    cyc();
    ls_req_valid = 1'b0;
    mid();
    chk("t2_mem_req", mem_req, 1'b1);
    chk("t2_mem_we", mem_we, 1'b1);
    chk("t2_mem_wstrb", mem_wstrb, 4'hF);
    chk("t2_mem_addr", mem_addr, 32'h200);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t2_if_ready_access", if_req_ready, 1'b0);
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    cyc();
    mid();
    chk("t2_ls_rsp_valid", ls_rsp_valid, 1'b1);
    chk("t2_ls_rsp_rdata", ls_rsp_rdata, 32'h0);
    chk("t2_ls_rsp_err", ls_rsp_err, 1'b0);
    chk("t2_if_rsp_valid", if_rsp_valid, 1'b0);
    chk("t2_if_ready_resp", if_req_ready, 1'b0);
    cyc();
    mem_ack = 1'b0;
    mid();
    chk("t2_spurious_resp_ack", ls_rsp_valid, 1'b0);
    chk("t2_if_next", if_req_ready, 1'b1);
    cyc();
    if_req_valid = 1'b0;
    mid();
    chk("t2_if_mem_addr", mem_addr, 32'h104);
    chk("t2_if_mem_we", mem_we, 1'b0);
    chk("t2_if_mem_wstrb", mem_wstrb, 4'h0);
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 32'hA5A5A5A5;
    cyc();
    mem_ack = 1'b0;
    mid();
    chk("t2_if_rsp_valid2", if_rsp_valid, 1'b1);
    chk("t2_if_rsp_data2", if_rsp_data, 32'hA5A5A5A5);
    cyc();

    // 6: spurious ack in IDLE
    mem_ack   = 1'b1;
    mem_rdata = 32'h77777777;
    mid();
    chk("t6_idle_mem_req", mem_req, 1'b0);
    cyc();
    mem_ack = 1'b0;
    mid();
    chk("t6_no_if_rsp", if_rsp_valid, 1'b0);
    chk("t6_no_ls_rsp", ls_rsp_valid, 1'b0);
    chk("t6_mem_req", mem_req, 1'b0);
    cyc();

    // 3: LS hammering; IF forced through on the 5th and 10th grants
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b0;
    ls_req_addr  = 32'h300;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h400;
    for (int i = 0; i < 10; i++) begin
      exp_ls = !(i == 4 || i == 9);
      mid();
      chk($sformatf("t3_ls_ready_%0d", i), ls_req_ready, exp_ls);
      chk($sformatf("t3_if_ready_%0d", i), if_req_ready, !exp_ls);
      cyc();
      mem_ack   = 1'b1;
      mem_rdata = 32'h1000 + 32'(i);
      mid();
      chk($sformatf("t3_addr_%0d", i), mem_addr, exp_ls ? 32'h300 : 32'h400);
      cyc();
      mem_ack = 1'b0;
      mid();
      chk($sformatf("t3_ls_rsp_%0d", i), ls_rsp_valid, exp_ls);
      chk($sformatf("t3_if_rsp_%0d", i), if_rsp_valid, !exp_ls);
      if (exp_ls) chk($sformatf("t3_ls_rdata_%0d", i), ls_rsp_rdata, 32'h1000 + 32'(i));
      else        chk($sformatf("t3_if_data_%0d", i), if_rsp_data, 32'h1000 + 32'(i));
      cyc();
    end
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    cyc();

    // 4: LS load timeout
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b0;
    ls_req_addr  = 32'h500;
    mem_rdata    = 32'hFFFFFFFF;
    mid();
    chk("t4_ls_ready", ls_req_ready, 1'b1);
    cyc();
    ls_req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      mid();
      if (!mem_req) break;
      n++;
      cyc();
    end
    chk("t4_mem_req_cycles", n, 16);
    chk("t4_ls_rsp_valid", ls_rsp_valid, 1'b1);
    chk("t4_ls_rsp_err", ls_rsp_err, 1'b1);
    chk("t4_ls_rsp_rdata", ls_rsp_rdata, 32'h0);
    cyc();
    mid();
    chk("t4_rsp_pulse", ls_rsp_valid, 1'b0);
    chk("t4_err_clear", ls_rsp_err, 1'b0);
    cyc();

    // 5: reset in 2nd ACCESS cycle
    if_req_valid = 1'b1;
    if_req_addr  = 32'h600;
    mem_rdata    = 32'h0;
    mid();
    chk("t5_if_ready", if_req_ready, 1'b1);
    cyc();
    if_req_valid = 1'b0;
    mid();
    chk("t5_mem_req_a1", mem_req, 1'b1);
    cyc();
    rst = 1'b1;
    mid();
    chk("t5_mem_req_a2", mem_req, 1'b1);
    cyc();
    rst = 1'b0;
    mid();
    chk("t5_mem_req_after_rst", mem_req, 1'b0);
    chk("t5_no_if_rsp", if_rsp_valid, 1'b0);
    cyc();
    mid();
    chk("t5_no_late_rsp", if_rsp_valid, 1'b0);
    chk("t5_no_late_req", mem_req, 1'b0);
    cyc();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h700;
    mid();
    chk("t5_fresh_ready", if_req_ready, 1'b1);
    cyc();
    if_req_valid = 1'b0;
    mid();
    chk("t5_fresh_mem_req", mem_req, 1'b1);
    chk("t5_fresh_addr", mem_addr, 32'h700);
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = 32'h00000013;
    cyc();
    mem_ack = 1'b0;
    mid();
    chk("t5_fresh_rsp", if_rsp_valid, 1'b1);
    chk("t5_fresh_data", if_rsp_data, 32'h00000013);
    chk("t5_fresh_err", if_rsp_err, 1'b0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
